// File: rtl/mem_stage.sv
// mem_stage: RV32I MEM stage that runs loads/stores over a byte-serial 8-bit RAM port, little-endian.
// Optional ID-bypass outputs fwd_valid/fwd_addr/fwd_data exist only when MEM_FWD_EN is defined.

`ifndef OpLen
`define OpLen 6
`endif
`ifndef RegAddrLen
`define RegAddrLen 5
`endif
`ifndef NOP
`define NOP 6'd0
`endif
`ifndef ADD
`define ADD 6'd1
`endif
`ifndef LB
`define LB  6'd16
`define LH  6'd17
`define LW  6'd18
`define LBU 6'd19
`define LHU 6'd20
`define SB  6'd21
`define SH  6'd22
`define SW  6'd23
`endif

module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   valid_i,
  input  logic [`OpLen-1:0]      op_i,
  input  logic [`RegAddrLen-1:0] rd_addr_i,
  input  logic [XLEN-1:0]        rd_data_i,
  input  logic [ADDR_W-1:0]      mem_addr_i,
  input  logic [7:0]             ram_din,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic                   ram_wr,
  output logic [7:0]             ram_dout,
  output logic                   wb_valid,
  output logic [`RegAddrLen-1:0] rd_addr_o,
  output logic [XLEN-1:0]        rd_data_o,
  output logic                   mem_stall
`ifdef MEM_FWD_EN
  ,
  output logic                   fwd_valid,
  output logic [`RegAddrLen-1:0] fwd_addr,
  output logic [XLEN-1:0]        fwd_data
`endif
);

  localparam int NB = XLEN / 8;

  typedef logic [`OpLen-1:0] op_t;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  function automatic logic is_load(op_t op);
    return op inside {`LB, `LH, `LW, `LBU, `LHU};
  endfunction

  function automatic logic is_store(op_t op);
    return op inside {`SB, `SH, `SW};
  endfunction

  function automatic logic [2:0] size_of(op_t op);
    case (op)
      `LB, `LBU, `SB: size_of = 3'd1;
      `LH, `LHU, `SH: size_of = 3'd2;
      default:        size_of = 3'd4;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] extend(op_t op, logic [XLEN-1:0] w);
    case (op)
      `LB:     extend = {{(XLEN-8){w[7]}}, w[7:0]};
      `LBU:    extend = {{(XLEN-8){1'b0}}, w[7:0]};
      `LH:     extend = {{(XLEN-16){w[15]}}, w[15:0]};
      `LHU:    extend = {{(XLEN-16){1'b0}}, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(logic [XLEN-1:0] w, logic [2:0] k);
    byte_of = 8'h00;
    for (int i = 0; i < NB; i++)
      if (k == 3'(i)) byte_of = w[8*i +: 8];
  endfunction

  state_t                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d, cnt_m1;
  op_t                     op_q, op_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [XLEN-1:0]         data_q, data_d, assembled;
  logic [`RegAddrLen-1:0]  rd_q, rd_d, rd_addr_d;
  logic [XLEN-1:0]         rd_data_d;
  logic                    wb_valid_d, wr_req;

  assign cnt_m1 = cnt_q - 3'd1;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    rd_addr_d  = rd_addr_o;
    rd_data_d  = rd_data_o;
    ram_addr   = '0;
    ram_dout   = 8'h00;
    wr_req     = 1'b0;
    mem_stall  = 1'b0;

    // Byte cnt-1 arrives on ram_din this cycle; merge it into the bytes gathered so far.
    assembled = data_q;
    for (int i = 0; i < NB; i++)
      if (cnt_m1 == 3'(i)) assembled[8*i +: 8] = ram_din;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (is_load(op_i) || is_store(op_i)) begin
            mem_stall = 1'b1;
            ram_addr  = mem_addr_i;
            if (is_store(op_i)) begin
              ram_dout = rd_data_i[7:0];
              wr_req   = 1'b1;
            end
            op_d   = op_i;
            addr_d = mem_addr_i;
            data_d = rd_data_i;
            rd_d   = rd_addr_i;
            cnt_d  = 3'd1;
            if (is_store(op_i) && size_of(op_i) == 3'd1) begin
              state_d    = DONE;
              wb_valid_d = 1'b1;
              rd_addr_d  = '0;
              rd_data_d  = '0;
            end else begin
              state_d = ACCESS;
            end
          end else if (op_i != `NOP) begin
            wb_valid_d = 1'b1;
            rd_addr_d  = rd_addr_i;
            rd_data_d  = rd_data_i;
          end else begin
            rd_addr_d = '0;
            rd_data_d = '0;
          end
        end
      end

      ACCESS: begin
        mem_stall = 1'b1;
        if (is_store(op_q)) begin
          ram_addr = addr_q + ADDR_W'(cnt_q);
          ram_dout = byte_of(data_q, cnt_q);
          wr_req   = 1'b1;
          if (cnt_q == size_of(op_q) - 3'd1) begin
            state_d    = DONE;
            wb_valid_d = 1'b1;
            rd_addr_d  = '0;
            rd_data_d  = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          // While frozen, re-present the byte still owed so ram_din carries it when rdy returns.
          ram_addr = addr_q + ADDR_W'(rdy ? cnt_q : cnt_m1);
          data_d   = assembled;
          if (cnt_q == size_of(op_q)) begin
            state_d    = DONE;
            wb_valid_d = 1'b1;
            rd_addr_d  = rd_q;
            rd_data_d  = extend(op_q, assembled);
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end

      default: state_d = IDLE;
    endcase
  end

  assign ram_wr = wr_req & rdy & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      op_q      <= `NOP;
      addr_q    <= '0;
      data_q    <= '0;
      rd_q      <= '0;
      wb_valid  <= 1'b0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
    end else if (rdy) begin
      // NOTE: non-blocking assignments, so every register here samples its pre-edge inputs.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rd_q      <= rd_d;
      wb_valid  <= wb_valid_d;
      rd_addr_o <= rd_addr_d;
      rd_data_o <= rd_data_d;
    end
  end

`ifdef MEM_FWD_EN
  assign fwd_valid = wb_valid_d & ~mem_stall;
  assign fwd_addr  = rd_addr_d;
  assign fwd_data  = rd_data_d;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table, hand sequences and randomized transactions for mem_stage,
// checked against a byte-addressed RAM image and a transaction-level reference model.

`ifndef OpLen
`define OpLen 6
`endif
`ifndef RegAddrLen
`define RegAddrLen 5
`endif
`ifndef NOP
`define NOP 6'd0
`endif
`ifndef ADD
`define ADD 6'd1
`endif
`ifndef LB
`define LB  6'd16
`define LH  6'd17
`define LW  6'd18
`define LBU 6'd19
`define LHU 6'd20
`define SB  6'd21
`define SH  6'd22
`define SW  6'd23
`endif

module tb_mem_stage;

  logic                   clk;
  logic                   rst, rdy, valid_i;
  logic [`OpLen-1:0]      op_i;
  logic [`RegAddrLen-1:0] rd_addr_i;
  logic [31:0]            rd_data_i, mem_addr_i;
  logic [7:0]             ram_din;
  logic [31:0]            ram_addr;
  logic                   ram_wr;
  logic [7:0]             ram_dout;
  logic                   wb_valid;
  logic [`RegAddrLen-1:0] rd_addr_o;
  logic [31:0]            rd_data_o;
  logic                   mem_stall;

  mem_stage #(.ADDR_W(32), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .valid_i(valid_i), .op_i(op_i),
    .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .mem_addr_i(mem_addr_i),
    .ram_din(ram_din), .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout),
    .wb_valid(wb_valid), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .mem_stall(mem_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] a; logic [7:0] d; } wr_t;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] addr;
    int          st_at;
    int          st_len;
    int          lat;
    logic [4:0]  ra;
    logic [31:0] rdd;
  } vec_t;

  localparam int NV = 16;
  vec_t vt [NV];

  logic [5:0] ops [9] = '{`ADD, `LB, `LH, `LW, `LBU, `LHU, `SB, `SH, `SW};

  wr_t        wr_log [$];
  wr_t        exp_wr [$];
  logic [7:0] ram_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];
  int total = 0, bad = 0, frozen_wr = 0;

  function automatic logic [7:0] pat(logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : pat(a);
  endfunction

  function automatic logic [7:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction

  // RAM: read data is registered (one cycle after the address), writes land on the edge.
  always @(posedge clk) begin
    ram_din <= ram_rd(ram_addr);
    if (ram_wr) begin
      if (!rdy) frozen_wr++;
      ram_mem[ram_addr] = ram_dout;
      wr_log.push_back('{ram_addr, ram_dout});
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic seed(input logic [31:0] a, input logic [7:0] d);
    ram_mem[a] = d;
    ref_mem[a] = d;
  endtask

  // Transaction-level reference: latency without stalls, writeback bundle and expected RAM writes.
  task automatic model(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] data,
                       input logic [31:0] addr, output int lat, output logic [4:0] ra,
                       output logic [31:0] rdd, output logic stall);
    int n;
    logic [31:0] v, a;
    n = (op inside {`LB, `LBU, `SB}) ? 1 : (op inside {`LH, `LHU, `SH}) ? 2 : 4;
    exp_wr.delete();
    if (op < `LB) begin
      lat = 1; ra = rd; rdd = data; stall = 1'b0;
    end else if (op inside {`SB, `SH, `SW}) begin
      for (int k = 0; k < n; k++) begin
        a = addr + 32'(k);
        exp_wr.push_back('{a, 8'(data >> (8 * k))});
        ref_mem[a] = 8'(data >> (8 * k));
      end
      lat = n; ra = '0; rdd = '0; stall = 1'b1;
    end else begin
      v = '0;
      for (int k = 0; k < n; k++) v = v | (32'(ref_rd(addr + 32'(k))) << (8 * k));
      if (op == `LB)      v = ((v & 32'hFF) ^ 32'h80) - 32'h80;
      else if (op == `LH) v = ((v & 32'hFFFF) ^ 32'h8000) - 32'h8000;
      lat = n + 1; ra = rd; rdd = v; stall = 1'b1;
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, "/wr_count"}, 64'(wr_log.size()), 64'(exp_wr.size()));
    for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++) begin
      check($sformatf("%s/wr%0d_addr", tag, i), 64'(wr_log[i].a), 64'(exp_wr[i].a));
      check($sformatf("%s/wr%0d_data", tag, i), 64'(wr_log[i].d), 64'(exp_wr[i].d));
    end
  endtask

  // Presents one bundle (held while upstream would be frozen), optionally drops rdy for
  // st_len cycles starting st_at cycles after accept, and reports when wb_valid appears.
  task automatic do_op(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] data,
                       input logic [31:0] addr, input int st_at, input int st_len,
                       output int lat, output logic [4:0] ra, output logic [31:0] rdd,
                       output logic acc_stall);
    wr_log.delete();
    valid_i = 1'b1; op_i = op; rd_addr_i = rd; rd_data_i = data; mem_addr_i = addr; rdy = 1'b1;
    #1 acc_stall = mem_stall;
    lat = -1; ra = '0; rdd = '0;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      @(posedge clk); #2;
      if (op < `LB) valid_i = 1'b0;
      if (wb_valid) begin
        lat = c; ra = rd_addr_o; rdd = rd_data_o;
      end else begin
        rdy = !(c >= st_at && c < st_at + st_len);
      end
    end
    valid_i = 1'b0; rdy = 1'b1;
    check("wb_valid_timeout", 64'(lat >= 0), 64'd1);
    @(posedge clk); #2;
    check("wb_valid_pulse", 64'(wb_valid), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/wb_valid"},  64'(wb_valid),  64'd0);
    check({tag, "/rd_addr_o"}, 64'(rd_addr_o), 64'd0);
    check({tag, "/rd_data_o"}, 64'(rd_data_o), 64'd0);
    check({tag, "/ram_addr"},  64'(ram_addr),  64'd0);
    check({tag, "/ram_wr"},    64'(ram_wr),    64'd0);
    check({tag, "/ram_dout"},  64'(ram_dout),  64'd0);
    check({tag, "/mem_stall"}, 64'(mem_stall), 64'd0);
  endtask

  initial begin
    int          d_lat, m_lat, st_at, st_len;
    logic [4:0]  d_ra, m_ra, rd;
    logic [31:0] d_rdd, m_rdd, data, addr;
    logic        d_stall, m_stall;
    logic [5:0]  op;

    vt[0]  = '{`ADD, 5'd5,  32'h0000_1234, 32'h0000_0000, 0, 0, 1, 5'd5,  32'h0000_1234};
    vt[1]  = '{`LW,  5'd3,  32'h0,         32'h0000_0100, 0, 0, 5, 5'd3,  32'h1234_5678};
    vt[2]  = '{`LB,  5'd4,  32'h0,         32'h0000_0007, 0, 0, 2, 5'd4,  32'hFFFF_FF80};
    vt[3]  = '{`LBU, 5'd4,  32'h0,         32'h0000_0007, 0, 0, 2, 5'd4,  32'h0000_0080};
    vt[4]  = '{`SH,  5'd9,  32'hAABB_CCDD, 32'h0000_0020, 0, 0, 2, 5'd0,  32'h0};
    vt[5]  = '{`LW,  5'd3,  32'h0,         32'h0000_0100, 2, 3, 8, 5'd3,  32'h1234_5678};
    vt[6]  = '{`LH,  5'd6,  32'h0,         32'h0000_0101, 0, 0, 3, 5'd6,  32'h0000_3456};
    vt[7]  = '{`LH,  5'd6,  32'h0,         32'h0000_0200, 0, 0, 3, 5'd6,  32'hFFFF_C234};
    vt[8]  = '{`LHU, 5'd6,  32'h0,         32'h0000_0200, 0, 0, 3, 5'd6,  32'h0000_C234};
    vt[9]  = '{`SB,  5'd1,  32'h0000_0055, 32'h0000_0030, 0, 0, 1, 5'd0,  32'h0};
    vt[10] = '{`SW,  5'd2,  32'hCAFE_BABE, 32'hFFFF_FFFE, 0, 0, 4, 5'd0,  32'h0};
    vt[11] = '{`LW,  5'd8,  32'h0,         32'hFFFF_FFFE, 0, 0, 5, 5'd8,  32'hCAFE_BABE};
    vt[12] = '{`LW,  5'd0,  32'h0,         32'h0000_0100, 0, 0, 5, 5'd0,  32'h1234_5678};
    vt[13] = '{`SW,  5'd2,  32'h0BAD_F00D, 32'h0000_0040, 2, 2, 6, 5'd0,  32'h0};
    vt[14] = '{`LHU, 5'd10, 32'h0,         32'h0000_0040, 0, 0, 3, 5'd10, 32'h0000_F00D};
    vt[15] = '{`LB,  5'd11, 32'h0,         32'h0000_0042, 1, 1, 3, 5'd11, 32'hFFFF_FFAD};

    seed(32'h100, 8'h78); seed(32'h101, 8'h56); seed(32'h102, 8'h34); seed(32'h103, 8'h12);
    seed(32'h007, 8'h80); seed(32'h200, 8'h34); seed(32'h201, 8'hC2);

    rst = 1'b1; rdy = 1'b1; valid_i = 1'b0; op_i = `NOP;
    rd_addr_i = '0; rd_data_i = '0; mem_addr_i = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("reset");

    for (int i = 0; i < NV; i++) begin
      model(vt[i].op, vt[i].rd, vt[i].data, vt[i].addr, m_lat, m_ra, m_rdd, m_stall);
      do_op(vt[i].op, vt[i].rd, vt[i].data, vt[i].addr, vt[i].st_at, vt[i].st_len,
            d_lat, d_ra, d_rdd, d_stall);
      check($sformatf("vec%0d/latency", i),   64'(d_lat), 64'(vt[i].lat));
      check($sformatf("vec%0d/rd_addr_o", i), 64'(d_ra),  64'(vt[i].ra));
      check($sformatf("vec%0d/rd_data_o", i), 64'(d_rdd), 64'(vt[i].rdd));
      check($sformatf("vec%0d/accept_stall", i), 64'(d_stall), 64'(m_stall));
      check_writes($sformatf("vec%0d", i));
    end

    // A valid NOP produces no writeback and no stall.
    valid_i = 1'b1; op_i = `NOP; rd_addr_i = 5'd12; rd_data_i = 32'h5555;
    #1 check("nop/mem_stall", 64'(mem_stall), 64'd0);
    @(posedge clk); #2 valid_i = 1'b0;
    check("nop/wb_valid", 64'(wb_valid), 64'd0);
    check("nop/rd_addr_o", 64'(rd_addr_o), 64'd0);

    // Reset during byte 2 of a SW aborts cleanly; bytes already written stay written.
    do_op(`ADD, 5'd7, 32'h0000_BEEF, 32'h0, 0, 0, d_lat, d_ra, d_rdd, d_stall);
    check("pre_rst/rd_addr_o", 64'(d_ra), 64'd7);
    valid_i = 1'b1; op_i = `SW; rd_addr_i = 5'd3; rd_data_i = 32'h1122_3344; mem_addr_i = 32'h50;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b1; valid_i = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    #1 check_reset_outputs("mid_sw_rst");
    check("mid_sw_rst/byte0", 64'(ram_rd(32'h50)), 64'h44);
    check("mid_sw_rst/byte1", 64'(ram_rd(32'h51)), 64'h33);
    do_op(`ADD, 5'd9, 32'h0000_0777, 32'h0, 0, 0, d_lat, d_ra, d_rdd, d_stall);
    check("post_rst/latency", 64'(d_lat), 64'd1);
    check("post_rst/rd_data_o", 64'(d_rdd), 64'h777);

    for (int i = 0; i < 40; i++) begin
      op   = ops[$urandom_range(0, 8)];
      rd   = 5'($urandom);
      data = $urandom;
      addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                         : 32'h300 + 32'($urandom_range(0, 63));
      model(op, rd, data, addr, m_lat, m_ra, m_rdd, m_stall);
      st_at = 0; st_len = 0;
      if (m_lat >= 2 && $urandom_range(0, 1) == 1) begin
        st_at  = $urandom_range(1, m_lat - 1);
        st_len = $urandom_range(1, 3);
      end
      do_op(op, rd, data, addr, st_at, st_len, d_lat, d_ra, d_rdd, d_stall);
      check($sformatf("rnd%0d/latency", i),   64'(d_lat), 64'(m_lat + st_len));
      check($sformatf("rnd%0d/rd_addr_o", i), 64'(d_ra),  64'(m_ra));
      check($sformatf("rnd%0d/rd_data_o", i), 64'(d_rdd), 64'(m_rdd));
      check($sformatf("rnd%0d/accept_stall", i), 64'(d_stall), 64'(m_stall));
      check_writes($sformatf("rnd%0d", i));
    end

    check("no_write_while_frozen", 64'(frozen_wr), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
